// File: rtl/seven_segment_scan_reader_pkg.sv
// Segment patterns (seg[6:0] = a..g, active-low) and BCD codes shared by the scan reader.
package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b0000001;
  localparam logic [6:0] SEG7_1     = 7'b1001111;
  localparam logic [6:0] SEG7_2     = 7'b0010010;
  localparam logic [6:0] SEG7_3     = 7'b0000110;
  localparam logic [6:0] SEG7_4     = 7'b1001100;
  localparam logic [6:0] SEG7_5     = 7'b0100100;
  localparam logic [6:0] SEG7_6     = 7'b0100000;
  localparam logic [6:0] SEG7_7     = 7'b0001111;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0000100;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [3:0] BCD_ERR    = 4'hE;
  localparam logic [3:0] BCD_BLANK  = 4'hF;

endpackage

// File: rtl/seven_segment_scan_reader_if.sv
// Display-pin and frame-output bundle; slave is the reader, master drives the pins and ready.
interface seven_segment_scan_reader_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] digits_out;
  logic [NUM_DIGITS-1:0]   digit_err_out;
  logic                    frame_valid;
  logic                    frame_ready;
  logic                    overflow_out;

  modport master (
    output seg_in, an_in, frame_ready,
    input  digits_out, digit_err_out, frame_valid, overflow_out
  );

  modport slave (
    input  seg_in, an_in, frame_ready,
    output digits_out, digit_err_out, frame_valid, overflow_out
  );

endinterface

// File: rtl/seven_segment_scan_reader_decode.sv
// Combinational segment-pattern to BCD lookup. SEG7_BLANK_DIGIT_EN makes all-off decode to BCD_BLANK.
module seven_segment_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_bcd,
  output logic       o_err
);

  always_comb begin
    o_bcd = BCD_ERR;
    o_err = 1'b1;
    case (i_seg)
      SEG7_0: begin o_bcd = 4'd0; o_err = 1'b0; end
      SEG7_1: begin o_bcd = 4'd1; o_err = 1'b0; end
      SEG7_2: begin o_bcd = 4'd2; o_err = 1'b0; end
      SEG7_3: begin o_bcd = 4'd3; o_err = 1'b0; end
      SEG7_4: begin o_bcd = 4'd4; o_err = 1'b0; end
      SEG7_5: begin o_bcd = 4'd5; o_err = 1'b0; end
      SEG7_6: begin o_bcd = 4'd6; o_err = 1'b0; end
      SEG7_7: begin o_bcd = 4'd7; o_err = 1'b0; end
      SEG7_8: begin o_bcd = 4'd8; o_err = 1'b0; end
      SEG7_9: begin o_bcd = 4'd9; o_err = 1'b0; end
`ifdef SEG7_BLANK_DIGIT_EN
      SEG7_BLANK: begin o_bcd = BCD_BLANK; o_err = 1'b0; end
`else
      SEG7_BLANK: begin o_bcd = BCD_ERR; o_err = 1'b1; end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/seven_segment_scan_reader.sv
// Recovers BCD digits from a multiplexed active-low 7-segment bus and emits one frame per scan.
// Blank-digit decoding is selected by SEG7_BLANK_DIGIT_EN (see seven_segment_pattern_decode).
module seven_segment_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  seven_segment_scan_reader_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [6:0]                  r_seg, r_pat;
  logic [NUM_DIGITS-1:0]       r_an;
  logic [IDX_W-1:0]            r_idx;
  logic [CNT_W-1:0]            r_cnt;
  logic                        r_latched;
  logic [NUM_DIGITS-1:0][3:0]  r_shadow;
  logic [NUM_DIGITS-1:0]       r_shadow_err, r_seen;
  logic [4*NUM_DIGITS-1:0]     r_digits;
  logic [NUM_DIGITS-1:0]       r_err;
  logic                        r_valid, r_ovf;

  logic [NUM_DIGITS-1:0]       w_an_act, w_latch_mask, w_seen_all, w_seen_d, w_shadow_err_d;
  logic [NUM_DIGITS-1:0][3:0]  w_shadow_d;
  logic [IDX_W-1:0]            w_idx;
  logic [CNT_W-1:0]            w_cnt_d;
  logic [3:0]                  w_dec_bcd;
  logic                        w_dec_err, w_strobe_ok, w_same, w_latch, w_latched_d;
  logic                        w_complete, w_can_load, w_valid_d, w_ovf_d;

  seven_segment_pattern_decode u_decode (
    .i_seg (r_pat),
    .o_bcd (w_dec_bcd),
    .o_err (w_dec_err)
  );

  always_comb begin
    w_an_act    = ~r_an;
    w_strobe_ok = $onehot(w_an_act);
    w_idx       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_an_act[i]) w_idx = IDX_W'(i);
    end
    w_same = w_strobe_ok && (w_idx == r_idx) && (r_seg == r_pat);

    // r_pat/r_idx hold the dwell just counted, so the latch fires one edge after the count saturates.
    w_latch = (r_cnt == CNT_MAX) && !r_latched;

    if (!w_strobe_ok)          w_cnt_d = '0;
    else if (!w_same)          w_cnt_d = CNT_W'(1);
    else if (r_cnt == CNT_MAX) w_cnt_d = CNT_MAX;
    else                       w_cnt_d = r_cnt + 1'b1;
    w_latched_d = w_same && (r_latched || w_latch);

    w_latch_mask   = '0;
    w_shadow_d     = r_shadow;
    w_shadow_err_d = r_shadow_err;
    if (w_latch) begin
      w_latch_mask[r_idx]   = 1'b1;
      w_shadow_d[r_idx]     = w_dec_bcd;
      w_shadow_err_d[r_idx] = w_dec_err;
    end

    w_seen_all = r_seen | w_latch_mask;
    w_complete = &w_seen_all;
    w_seen_d   = w_complete ? '0 : w_seen_all;
    w_can_load = !r_valid || bus.frame_ready;

    if (w_complete && w_can_load) w_valid_d = 1'b1;
    else if (bus.frame_ready)     w_valid_d = 1'b0;
    else                          w_valid_d = r_valid;
    w_ovf_d = w_complete && !w_can_load;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= '0;
      r_an         <= '0;
      r_pat        <= '0;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_latched    <= 1'b0;
      r_shadow     <= '0;
      r_shadow_err <= '0;
      r_seen       <= '0;
      r_digits     <= '0;
      r_err        <= '0;
      r_valid      <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_seg        <= bus.seg_in;
      r_an         <= bus.an_in;
      r_pat        <= r_seg;
      r_idx        <= w_idx;
      r_cnt        <= w_cnt_d;
      r_latched    <= w_latched_d;
      r_shadow     <= w_shadow_d;
      r_shadow_err <= w_shadow_err_d;
      r_seen       <= w_seen_d;
      r_valid      <= w_valid_d;
      r_ovf        <= w_ovf_d;
      if (w_complete && w_can_load) begin
        r_digits <= w_shadow_d;
        r_err    <= w_shadow_err_d;
      end
    end
  end

  assign bus.digits_out    = r_digits;
  assign bus.digit_err_out = r_err;
  assign bus.frame_valid   = r_valid;
  assign bus.overflow_out  = r_ovf;

endmodule
